// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack round controller and its helpers.
package blackjack_pkg;

  localparam int CARD_W       = 4;
  localparam int DEALER_STAND = 17;
  localparam int BUST_LIMIT   = 21;

  localparam logic TO_PLAYER = 1'b0;
  localparam logic TO_DEALER = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DELAY,
    S_PLAYER,
    S_DEALER,
    S_DONE
  } deal_state_t;

endpackage

// File: rtl/deal_delay_timer.sv
// Inter-deal pause counter: counts up while enabled and flags when it reaches the limit.
module deal_delay_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Saturates at the limit so the count can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     count <= '0;
    else if (clear)                   count <= '0;
    else if (enable && count < limit) count <= count + WIDTH'(1);
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/deal_sequencer.sv
// One blackjack round: initial deal P0,D0,P1,D1, player hit/stand, dealer draws to 17,
// with a programmable pause after every dealt card.
module deal_sequencer
  import blackjack_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HAND = 5,
  parameter int SLOT_W   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              hit,
  input  logic              stand,
  input  logic [WIDTH-1:0]  delay,
  input  logic [5:0]        player_score,
  input  logic [5:0]        dealer_score,
  output logic              card_req,
  input  logic              card_ack,
  input  logic [CARD_W-1:0] card_val,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_out,
  output logic              deal_to,
  output logic [SLOT_W-1:0] slot,
  output logic              clear_hands,
  output logic              player_turn,
  output logic              busy,
  output logic              done
);

  // One extra bit so a full hand (count == MAX_HAND) is representable even when
  // 2**SLOT_W == MAX_HAND.
  localparam int              CNT_W     = SLOT_W + 1;
  localparam logic [CNT_W-1:0] HAND_FULL = CNT_W'(MAX_HAND);

  deal_state_t      state, nxt;
  logic             target, nxt_target;
  logic             dealing;
  logic [1:0]       deal_idx;
  logic [CNT_W-1:0] p_cnt, d_cnt;
  logic             start_ok, take, expired, deal_last;

  assign start_ok    = start && (state == S_IDLE || state == S_DONE);
  assign take        = (state == S_REQ) && card_ack;
  assign deal_last   = (state == S_DELAY) && expired && dealing && (deal_idx == 2'd0);
  assign card_req    = (state == S_REQ);
  assign player_turn = (state == S_PLAYER);

  deal_delay_timer #(.WIDTH(WIDTH)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (take),
    .enable  (state == S_DELAY),
    .limit   (delay),
    .expired (expired)
  );

  always_comb begin
    nxt        = state;
    nxt_target = target;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt        = S_REQ;
          nxt_target = TO_PLAYER;
        end
      end
      S_REQ: begin
        if (card_ack) nxt = S_DELAY;
      end
      S_DELAY: begin
        if (expired) begin
          // deal_idx has already advanced past the card just dealt; wrapping to 0
          // means the four opening cards are out.
          if (dealing) begin
            if (deal_idx == 2'd0) begin
              nxt = S_PLAYER;
            end else begin
              nxt        = S_REQ;
              nxt_target = deal_idx[0];
            end
          end else begin
            nxt = (target == TO_PLAYER) ? S_PLAYER : S_DEALER;
          end
        end
      end
      S_PLAYER: begin
        if (player_score > 6'(BUST_LIMIT)) begin
          nxt = S_DONE;
        end else if (stand) begin
          nxt = S_DEALER;
        end else if (hit) begin
          if (p_cnt == HAND_FULL) begin
            nxt = S_DEALER;
          end else begin
            nxt        = S_REQ;
            nxt_target = TO_PLAYER;
          end
        end
      end
      S_DEALER: begin
        if (dealer_score >= 6'(DEALER_STAND) || d_cnt == HAND_FULL) begin
          nxt = S_DONE;
        end else begin
          nxt        = S_REQ;
          nxt_target = TO_DEALER;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      target      <= TO_PLAYER;
      dealing     <= 1'b0;
      deal_idx    <= 2'd0;
      p_cnt       <= '0;
      d_cnt       <= '0;
      card_valid  <= 1'b0;
      card_out    <= '0;
      deal_to     <= 1'b0;
      slot        <= '0;
      clear_hands <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt;
      target      <= nxt_target;
      card_valid  <= 1'b0;
      clear_hands <= 1'b0;

      if (start_ok) begin
        clear_hands <= 1'b1;
        p_cnt       <= '0;
        d_cnt       <= '0;
        deal_idx    <= 2'd0;
        dealing     <= 1'b1;
        busy        <= 1'b1;
        done        <= 1'b0;
      end

      if (take) begin
        card_valid <= 1'b1;
        card_out   <= card_val;
        deal_to    <= target;
        if (target == TO_DEALER) begin
          slot  <= d_cnt[SLOT_W-1:0];
          d_cnt <= d_cnt + CNT_W'(1);
        end else begin
          slot  <= p_cnt[SLOT_W-1:0];
          p_cnt <= p_cnt + CNT_W'(1);
        end
        if (dealing) deal_idx <= deal_idx + 2'd1;
      end

      if (deal_last) dealing <= 1'b0;

      if (nxt == S_DONE && state != S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: four rounds driven by a scripted deck, with every
// dealt card checked against a hand-written table.
module tb_deal_sequencer;

  localparam int WIDTH    = 16;
  localparam int MAX_HAND = 5;
  localparam int SLOT_W   = 3;
  localparam int NCARD    = 24;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, hit = 1'b0, stand = 1'b0;
  logic [WIDTH-1:0]  delay = 16'd3;
  logic [5:0]        player_score = 6'd0, dealer_score = 6'd0;
  logic              card_req;
  logic              card_ack = 1'b0;
  logic [3:0]        card_val = 4'd0;
  logic              card_valid;
  logic [3:0]        card_out;
  logic              deal_to;
  logic [SLOT_W-1:0] slot;
  logic              clear_hands, player_turn, busy, done;

  deal_sequencer #(.WIDTH(WIDTH), .MAX_HAND(MAX_HAND), .SLOT_W(SLOT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .hit          (hit),
    .stand        (stand),
    .delay        (delay),
    .player_score (player_score),
    .dealer_score (dealer_score),
    .card_req     (card_req),
    .card_ack     (card_ack),
    .card_val     (card_val),
    .card_valid   (card_valid),
    .card_out     (card_out),
    .deal_to      (deal_to),
    .slot         (slot),
    .clear_hands  (clear_hands),
    .player_turn  (player_turn),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int to;
    int slot;
  } card_vec_t;

  card_vec_t tbl[NCARD];
  int        deck_q[$];
  bit        deck_en = 1'b1;
  int        log_val[32], log_to[32], log_slot[32], log_cyc[32];
  int        ncards = 0;
  int        nvec = 0, nfail = 0;

  // Deck: acks on the third falling edge that sees card_req, drops ack one cycle later.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!deck_en) begin
        wait_cnt = 0;
      end else if (card_ack) begin
        card_ack = 1'b0;
        wait_cnt = 0;
      end else if (card_req) begin
        if (wait_cnt == 2) begin
          card_ack = 1'b1;
          card_val = (deck_q.size() > 0) ? 4'(deck_q.pop_front()) : 4'd0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (card_valid === 1'b1) begin
        if (ncards < 32) begin
          log_val[ncards]  = int'(card_out);
          log_to[ncards]   = int'(deal_to);
          log_slot[ncards] = int'(slot);
          log_cyc[ncards]  = cyc;
        end
        ncards++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // sel: 0 player_turn, 1 done, 2 card_req
  task automatic wait_sig(input int sel, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ((sel == 0 && player_turn) || (sel == 1 && done) || (sel == 2 && card_req)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({"wait_", nm}, int'(ok), 1);
  endtask

  task automatic wait_cards(input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ncards >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({"wait_", nm}, int'(ok), 1);
  endtask

  task automatic pulse(input bit h, input bit s);
    hit   = h;
    stand = s;
    @(negedge clk);
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_clear_hands"}, int'(clear_hands), 1);
    chk({nm, "_busy"}, int'(busy), 1);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    // Expected card stream across all four rounds, in dealing order.
    tbl[0]  = '{5, 0, 0};  tbl[1]  = '{10, 1, 0}; tbl[2]  = '{7, 0, 1};  tbl[3]  = '{2, 1, 1};
    tbl[4]  = '{2, 0, 2};  tbl[5]  = '{3, 0, 3};  tbl[6]  = '{2, 0, 4};
    tbl[7]  = '{4, 0, 0};  tbl[8]  = '{6, 1, 0};  tbl[9]  = '{3, 0, 1};  tbl[10] = '{9, 1, 1};
    tbl[11] = '{5, 0, 2};  tbl[12] = '{8, 0, 3};  tbl[13] = '{9, 0, 4};
    tbl[14] = '{8, 0, 0};  tbl[15] = '{7, 1, 0};  tbl[16] = '{7, 0, 1};  tbl[17] = '{5, 1, 1};
    tbl[18] = '{3, 1, 2};  tbl[19] = '{4, 1, 3};
    tbl[20] = '{2, 0, 0};  tbl[21] = '{3, 1, 0};  tbl[22] = '{4, 0, 1};  tbl[23] = '{5, 1, 1};
    for (int i = 0; i < NCARD; i++) deck_q.push_back(tbl[i].val);

    repeat (3) @(negedge clk);
    chk("rst_card_req", int'(card_req), 0);
    chk("rst_card_valid", int'(card_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_player_turn", int'(player_turn), 0);
    chk("rst_clear_hands", int'(clear_hands), 0);
    chk("rst_slot", int'(slot), 0);
    chk("rst_card_out", int'(card_out), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Round 1: initial deal spacing, then three hits up to a full hand and a capped hit.
    player_score = 6'd12;
    dealer_score = 6'd18;
    do_start("r1");
    wait_sig(0, "r1_turn");
    chk("r1_initial_cards", ncards, 4);
    // 4 DELAY cycles + 3 REQ cycles with this deck's ack latency
    for (int i = 1; i < 4; i++) chk("r1_strobe_gap", log_cyc[i] - log_cyc[i-1], 7);
    repeat (3) begin
      pulse(1'b1, 1'b0);
      wait_sig(0, "r1_hit_turn");
    end
    chk("r1_full_hand", ncards, 7);
    pulse(1'b1, 1'b0);
    chk("cap_left_player", int'(player_turn), 0);
    wait_sig(1, "r1_done");
    chk("cap_no_card", ncards, 7);
    chk("r1_busy_off", int'(busy), 0);

    // Round 2: player busts after the third hit; dealer draws nothing.
    player_score = 6'd10;
    do_start("r2");
    wait_sig(0, "r2_turn");
    chk("r2_initial_cards", ncards, 11);
    pulse(1'b1, 1'b0);
    wait_sig(0, "r2_turn_a");
    pulse(1'b1, 1'b0);
    wait_sig(0, "r2_turn_b");
    pulse(1'b1, 1'b0);
    player_score = 6'd24;
    wait_sig(1, "r2_done");
    chk("bust_no_dealer_card", ncards, 14);
    chk("bust_done", int'(done), 1);
    chk("bust_busy", int'(busy), 0);
    chk("bust_player_turn", int'(player_turn), 0);

    // Round 3: hit+stand together, then dealer draws 12 -> 15 -> 19.
    player_score = 6'd15;
    dealer_score = 6'd12;
    do_start("r3");
    wait_sig(0, "r3_turn");
    chk("r3_initial_cards", ncards, 18);
    pulse(1'b1, 1'b1);
    chk("hs_left_player", int'(player_turn), 0);
    chk("hs_no_req_yet", int'(card_req), 0);
    wait_cards(19, "r3_dealer_a");
    dealer_score = 6'd15;
    wait_cards(20, "r3_dealer_b");
    dealer_score = 6'd19;
    wait_sig(1, "r3_done");
    chk("dealer_two_cards", ncards, 20);
    chk("dealer_done", int'(done), 1);

    // Round 4: reset while the deck is stalled mid-request.
    deck_en      = 1'b0;
    player_score = 6'd10;
    dealer_score = 6'd18;
    do_start("r4");
    wait_sig(2, "r4_req");
    #3 reset_n = 1'b0;
    #1;
    chk("arst_card_req", int'(card_req), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_clear_hands", int'(clear_hands), 0);
    @(negedge clk);
    reset_n  = 1'b1;
    card_ack = 1'b1;
    card_val = 4'd9;
    repeat (2) begin
      @(negedge clk);
      chk("late_ack_no_valid", int'(card_valid), 0);
    end
    card_ack = 1'b0;
    chk("late_ack_no_card", ncards, 20);
    deck_en = 1'b1;
    do_start("r4b");
    wait_cards(21, "r4_first");
    chk("r4_first_slot", log_slot[20], 0);
    chk("r4_first_to", log_to[20], 0);
    wait_sig(0, "r4_turn");
    chk("total_cards", ncards, NCARD);

    for (int i = 0; i < NCARD; i++) begin
      chk($sformatf("card%0d_val", i), log_val[i], tbl[i].val);
      chk($sformatf("card%0d_to", i), log_to[i], tbl[i].to);
      chk($sformatf("card%0d_slot", i), log_slot[i], tbl[i].slot);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Game-flow controller for one blackjack round.
- Requests cards from the deck block over a req/ack handshake and routes each card to the player or dealer hand slot.
- Inserts a programmable inter-deal delay, using an internal tick counter, so card reveals are visible on the display.
- Runs player hit/stand, then draws for the dealer until 17. It sits between the deck/shuffler, the hand-score blocks and the display.

Parameters:
- WIDTH, 16, width of the delay input and the internal delay counter.
- MAX_HAND, 5, maximum number of cards per hand.
- SLOT_W, 3, width of the slot index; must satisfy 2**SLOT_W >= MAX_HAND.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a round.
- hit  in  1  debounced player hit pulse.
- stand  in  1  debounced player stand pulse.
- delay  in  WIDTH  inter-deal pause in clk cycles.
- player_score  in  6  registered player hand total from the score block.
- dealer_score  in  6  registered dealer hand total from the score block.
- card_req  out  1  card request to the deck.
- card_ack  in  1  deck acknowledge; card_val is valid in the same cycle.
- card_val  in  4  card rank from the deck.
- card_valid  out  1  one-cycle strobe: card_out/deal_to/slot are valid.
- card_out  out  4  dealt card rank.
- deal_to  out  1  0 = player, 1 = dealer.
- slot  out  SLOT_W  destination slot in the hand.
- clear_hands  out  1  one-cycle pulse when a round starts.
- player_turn  out  1  high while waiting for hit/stand.
- busy  out  1  high from an accepted start until DONE.
- done  out  1  high in DONE; round finished.

Behaviour:
- Reset: reset_n low forces IDLE asynchronously, at any time including mid-handshake. All outputs are 0, the slot counters are 0 and the delay counter is 0.
- States: IDLE, REQ, DELAY, PLAYER, DEALER, DONE.
- IDLE/DONE + start: the next state is REQ. clear_hands pulses for 1 cycle, both slot counters clear, busy=1, done=0, deal index=0. start is ignored in every other state.
- Initial deal order: P0, D0, P1, D1. It is driven by a 2-bit deal index; after the 4th card the next state is PLAYER.
- REQ:
  - card_req=1 and is held until card_ack is sampled high.
  - In the ack cycle the registered outputs update, so on the next cycle card_valid=1 for exactly 1 cycle, with card_out=card_val, deal_to and slot = the target hand's counter.
  - In that same next cycle card_req=0, the state is DELAY, the target slot counter increments and the delay counter is 0.
- card_ack outside REQ is ignored; no card is produced.
- DELAY:
  - The counter increments each cycle; on count==delay the next state is taken.
  - delay=0 gives exactly 1 cycle in DELAY, and delay=N gives N+1 cycles.
  - Counter arithmetic is WIDTH bits with no wrap: it only counts up to delay.
- Score timing: scores are sampled only in PLAYER and DEALER. Those states are entered at least 2 cycles after card_valid, which the score-block registering guarantees.
- PLAYER: player_turn=1. In priority order:
  - player_score>21 goes to DONE (bust).
  - stand goes to DEALER.
  - hit with player slot count==MAX_HAND goes to DEALER.
  - hit otherwise goes to REQ for the player.
  - If hit and stand arrive in the same cycle, stand wins.
- DEALER:
  - dealer_score>=17, or dealer count==MAX_HAND, goes to DONE.
  - Otherwise go to REQ for the dealer; after DELAY, return to DEALER.
- DONE: busy=0, done=1, held until start or reset.
- The deck never acks: the block waits in REQ indefinitely with no timeout; reset recovers it.

Decomposition:
- Shared package blackjack_pkg holds:
  - deal_state_t enum.
  - DEALER_STAND=17 and BUST_LIMIT=21.
  - TO_PLAYER=0 and TO_DEALER=1.
  - CARD_W=4.
- One sub-module, deal_delay_timer, with inputs clk, reset_n, clear, enable and limit, and output expired. It asserts expired when count==limit. The FSM clears it on entry to DELAY.

Test Plan:
- Initial deal with delay=3: reset, then start. The deck acks each request after 2 cycles with values 5,10,7,2. Required: 4 card_valid strobes at (deal_to,slot) = (0,0),(1,0),(0,1),(1,1) with those values. card_valid strobes are exactly 4 DELAY cycles + handshake apart. player_turn=1 afterwards.
- Player bust: player_score driven to 24 after the third hit. Required: done=1, dealer draws no cards, busy=0.
- Dealer draw-to-17: stand with dealer_score 12. The deck supplies 3 (score 15), then 4 (score 19). Required: exactly 2 dealer cards at slots 2 and 3, then done=1.
- Hit+stand simultaneous: pulse both together. Required: no player card; DEALER is entered.
- MAX_HAND cap: 3 hits with scores kept at or below 21. Required: player slots 2,3,4 are dealt; a 4th hit produces no card and the block moves to DEALER.
- Async reset mid-REQ: drop reset_n while card_req=1. Required: card_req=0 immediately and IDLE. A later ack produces no card_valid. A new start pulses clear_hands and deals from slot 0.
